// File: rtl/fp_pkg.sv
// Shared floating-point constants, state encoding and classification helpers
// for the sequential single-precision squarer.
package fp_pkg;

    localparam int          FP_BIAS     = 127;
    localparam logic [31:0] FP_QNAN     = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF     = 32'h7F80_0000;
    localparam logic [31:0] FP_ZERO     = 32'h0000_0000;
    localparam logic [7:0]  FP_EXP_ZERO = 8'h00;
    localparam logic [7:0]  FP_EXP_MAX  = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_NORM = 2'd2,
        ST_DONE = 2'd3
    } sq_state_t;

    function automatic logic fp_is_special(input logic [7:0] exp_f);
        return (exp_f == FP_EXP_ZERO) || (exp_f == FP_EXP_MAX);
    endfunction

    // Square of a zero/denormal/Inf/NaN operand; the sign is always dropped.
    function automatic logic [31:0] fp_special_square(input logic [31:0] op);
        logic [31:0] res;
        if (op[30:23] == FP_EXP_ZERO) begin
            res = FP_ZERO;
        end else if (op[22:0] != 23'd0) begin
            res = FP_QNAN;
        end else begin
            res = FP_PINF;
        end
        return res;
    endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// Radix-2 shift-add multiplier that squares a W-bit significand, one
// multiplier bit per clock; done is high during the final accumulation cycle.
module mant_mul_seq
    import fp_pkg::*;
#(
    parameter int W = 24
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   mant,
    output logic           done,
    output logic [2*W-1:0] acc
);
    localparam int CNT_W = $clog2(W);

    logic [W-1:0]     mant_r;
    logic [2*W-1:0]   acc_r;
    logic [2*W-1:0]   addend_s;
    logic [CNT_W-1:0] cnt_r;
    logic             busy_r;

    // Partial product for the current multiplier bit.
    always_comb begin
        addend_s = {(2*W){1'b0}};
        if (mant_r[cnt_r]) begin
            addend_s = {{W{1'b0}}, mant_r} << cnt_r;
        end else begin
            addend_s = {(2*W){1'b0}};
        end
    end

    // Iteration state: operand, accumulator and bit counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            mant_r <= {W{1'b0}};
            acc_r  <= {(2*W){1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b0;
        end else if (start) begin
            mant_r <= mant;
            acc_r  <= {(2*W){1'b0}};
            cnt_r  <= {CNT_W{1'b0}};
            busy_r <= 1'b1;
        end else if (busy_r) begin
            acc_r <= acc_r + addend_s;
            if (cnt_r == CNT_W'(W - 1)) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

    assign done = busy_r && (cnt_r == CNT_W'(W - 1));
    assign acc  = acc_r;

endmodule

// File: rtl/fp_square_seq.sv
// Sequential IEEE-754 single-precision squarer with valid/ready handshakes.
// Define FP_SQUARE_ROUND_NEAREST_EN for round-to-nearest-even (default truncates).
module fp_square_seq
    import fp_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    parameter int BIAS   = FP_BIAS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a_operand,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] solution,
    output logic        overflow,
    output logic        underflow
);
    localparam int ACC_W = 2 * MANT_W;
    localparam int E_W   = EXP_W + 2;
    localparam logic signed [E_W-1:0] EXP_OVF_C = E_W'((1 << EXP_W) - 1);

    sq_state_t          state_r, state_next_s;
    logic [EXP_W-1:0]   exp_r, exp_next_s;
    logic [31:0]        solution_r, solution_next_s;
    logic               overflow_r, overflow_next_s;
    logic               underflow_r, underflow_next_s;
    logic               out_valid_r, out_valid_next_s;
    logic               in_ready_r;
    logic               mul_start_s, mul_done_s;
    logic [ACC_W-1:0]   mul_acc_s;
    logic signed [E_W-1:0] norm_exp_s;
    logic [MANT_W-2:0]  norm_frac_s;
    logic [31:0]        norm_result_s;
    logic               norm_ovf_s, norm_unf_s;

    mant_mul_seq #(.W(MANT_W)) u_mul (
        .clk   (clk),
        .reset (reset),
        .start (mul_start_s),
        .mant  ({1'b1, a_operand[MANT_W-2:0]}),
        .done  (mul_done_s),
        .acc   (mul_acc_s)
    );

`ifdef FP_SQUARE_ROUND_NEAREST_EN
    logic norm_guard_s, norm_sticky_s, norm_carry_s;
`else
    logic unused_acc_s;
    assign unused_acc_s = ^mul_acc_s[MANT_W-2:0];
`endif

    // Exponent rebias, product normalisation, optional rounding and range limits.
    always_comb begin
        norm_exp_s = $signed({1'b0, exp_r, 1'b0}) - $signed(E_W'(BIAS));
        if (mul_acc_s[ACC_W-1]) begin
            norm_exp_s  = norm_exp_s + $signed(E_W'(1));
            norm_frac_s = mul_acc_s[ACC_W-2 -: MANT_W-1];
        end else begin
            norm_frac_s = mul_acc_s[ACC_W-3 -: MANT_W-1];
        end
`ifdef FP_SQUARE_ROUND_NEAREST_EN
        norm_carry_s = 1'b0;
        if (mul_acc_s[ACC_W-1]) begin
            norm_guard_s  = mul_acc_s[MANT_W-1];
            norm_sticky_s = |mul_acc_s[MANT_W-2:0];
        end else begin
            norm_guard_s  = mul_acc_s[MANT_W-2];
            norm_sticky_s = |mul_acc_s[MANT_W-3:0];
        end
        if (norm_guard_s && (norm_sticky_s || norm_frac_s[0])) begin
            {norm_carry_s, norm_frac_s} = {1'b0, norm_frac_s} + MANT_W'(1);
        end else begin
            norm_carry_s = 1'b0;
        end
        // A carry out of the fraction leaves it zero and bumps the exponent.
        if (norm_carry_s) begin
            norm_exp_s = norm_exp_s + $signed(E_W'(1));
        end else begin
            norm_exp_s = norm_exp_s;
        end
`endif
        norm_ovf_s    = 1'b0;
        norm_unf_s    = 1'b0;
        norm_result_s = {1'b0, norm_exp_s[EXP_W-1:0], norm_frac_s};
        if (norm_exp_s >= EXP_OVF_C) begin
            norm_result_s = FP_PINF;
            norm_ovf_s    = 1'b1;
        end else if (norm_exp_s <= $signed({E_W{1'b0}})) begin
            norm_result_s = FP_ZERO;
            norm_unf_s    = 1'b1;
        end else begin
            norm_ovf_s = 1'b0;
        end
    end

    // Handshake FSM next-state and output-register next values.
    always_comb begin
        state_next_s     = state_r;
        exp_next_s       = exp_r;
        solution_next_s  = solution_r;
        overflow_next_s  = overflow_r;
        underflow_next_s = underflow_r;
        out_valid_next_s = out_valid_r;
        mul_start_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    exp_next_s = a_operand[30 -: EXP_W];
                    if (fp_is_special(a_operand[30 -: EXP_W])) begin
                        solution_next_s  = fp_special_square(a_operand);
                        overflow_next_s  = 1'b0;
                        underflow_next_s = 1'b0;
                        out_valid_next_s = 1'b1;
                        state_next_s     = ST_DONE;
                    end else begin
                        mul_start_s  = 1'b1;
                        state_next_s = ST_MUL;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                if (mul_done_s) begin
                    state_next_s = ST_NORM;
                end else begin
                    state_next_s = ST_MUL;
                end
            end
            ST_NORM: begin
                solution_next_s  = norm_result_s;
                overflow_next_s  = norm_ovf_s;
                underflow_next_s = norm_unf_s;
                out_valid_next_s = 1'b1;
                state_next_s     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_next_s = 1'b0;
                    overflow_next_s  = 1'b0;
                    underflow_next_s = 1'b0;
                    state_next_s     = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            exp_r       <= {EXP_W{1'b0}};
            solution_r  <= FP_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
        end else begin
            state_r     <= state_next_s;
            exp_r       <= exp_next_s;
            solution_r  <= solution_next_s;
            overflow_r  <= overflow_next_s;
            underflow_r <= underflow_next_s;
            out_valid_r <= out_valid_next_s;
            in_ready_r  <= (state_next_s == ST_IDLE);
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign solution  = solution_r;
    assign overflow  = overflow_r;
    assign underflow = underflow_r;

endmodule

// File: tb/tb_fp_square_seq.sv
// Directed self-checking bench for fp_square_seq: values, latency, specials,
// range limits, output stall and mid-operation reset.
module tb_fp_square_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a_operand;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] solution;
    logic        overflow;
    logic        underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_square_seq dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_operand (a_operand),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .solution  (solution),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] exp_sol,
                          input logic exp_ovf, input logic exp_unf, input int exp_lat,
                          input int stall);
        int lat;
        int waitc;
        @(negedge clk);
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a_operand = a;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 1) in_valid = 1'b0;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " solution"}, solution, exp_sol);
        chk({tag, " overflow"}, 32'(overflow), 32'(exp_ovf));
        chk({tag, " underflow"}, 32'(underflow), 32'(exp_unf));
        chk({tag, " in_ready_busy"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, " stall_solution"}, solution, exp_sol);
            chk({tag, " stall_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, " flags_clear"}, {30'd0, overflow, underflow}, 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] rnd_exp;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a_operand = 32'd0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst solution", solution, 32'd0);
        chk("rst flags", {30'd0, overflow, underflow}, 32'd0);
        reset = 1'b0;

        run_op("sq3", 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0, 26, 0);
        run_op("sqm2", 32'hC000_0000, 32'h4080_0000, 1'b0, 1'b0, 26, 0);
        run_op("sq1p5", 32'h3FC0_0000, 32'h4010_0000, 1'b0, 1'b0, 26, 0);
        run_op("nan", 32'h7FC0_0001, 32'h7FC0_0000, 1'b0, 1'b0, 1, 0);
        run_op("ninf", 32'hFF80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1, 0);
        run_op("nzero", 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1, 0);
        run_op("denorm", 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 1, 0);
        run_op("ovf", 32'h7149_F2CA, 32'h7F80_0000, 1'b1, 1'b0, 26, 0);
        run_op("unf", 32'h0DA2_4260, 32'h0000_0000, 1'b0, 1'b1, 26, 0);
`ifdef FP_SQUARE_ROUND_NEAREST_EN
        rnd_exp = 32'h4010_0002;
`else
        rnd_exp = 32'h4010_0001;
`endif
        run_op("round", 32'h3FC0_0001, rnd_exp, 1'b0, 1'b0, 26, 0);
        run_op("stall", 32'h4040_0000, 32'h4110_0000, 1'b0, 1'b0, 26, 10);

        // Reset in the middle of the multiply: the operand must vanish.
        @(negedge clk);
        in_valid  = 1'b1;
        a_operand = 32'h4040_0000;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst in_ready", 32'(in_ready), 32'd1);
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst solution", solution, 32'd0);
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("midrst no_output", 32'(seen), 32'd0);

        run_op("recover", 32'hC000_0000, 32'h4080_0000, 1'b0, 1'b0, 26, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_square_seq.md
Name: fp_square_seq

Overview:
- Sequential IEEE-754 single-precision squarer (y = a*a), the forward operation of the combinational square-root unit. It is used to check and refine sqrt results in the FP ALU.
- A radix-2 shift-add mantissa multiplier iterates one bit per clock, which trades latency for area relative to the combinational Multiplication block.
- Valid/ready handshake on the input and output sides; one operation in flight.

Parameters:
- MANT_W, 24, significand width including hidden bit (fixed for single precision).
- EXP_W, 8, exponent width.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  a_operand is valid.
- in_ready  output  1  block can accept an operand.
- a_operand  input  32  IEEE-754 single operand.
- out_valid  output  1  solution is valid.
- out_ready  input  1  consumer accepts solution.
- solution  output  32  IEEE-754 result a*a.
- overflow  output  1  result saturated to +Inf; valid with out_valid.
- underflow  output  1  result flushed to +0; valid with out_valid.

Behaviour:
- One clock (clk); reset is synchronous and active-high. reset=1 at an edge forces state IDLE, in_ready=1, out_valid=0, solution=0, overflow=0, underflow=0. This holds even mid-operation: the in-flight operand is discarded with no output.
- States: IDLE, MUL, NORM, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch the operand.
  - If special (exp==0 or exp==255) → DONE directly, with the result below.
  - Else → MUL with mant={1,frac}, acc=0, cnt=0.
- MUL:
  - 24 cycles.
  - Each cycle: if multiplier bit[cnt]=1, add mant<<cnt into the 48-bit acc; cnt++.
  - After cnt==23 → NORM.
- NORM, 1 cycle:
  - e = 2*exp - BIAS, computed in 10-bit signed.
  - If acc[47]=1: e+=1, frac=acc[46:24]. Else frac=acc[45:23].
  - Default rounding is truncation.
  - If e>=255: result=32'h7F800000, overflow=1.
  - If e<=0: result=32'h00000000, underflow=1.
  - → DONE.
- DONE:
  - out_valid=1; solution and flags held stable until out_ready=1.
  - On the handshake: out_valid→0, flags→0, → IDLE.
  - in_ready=0 in DONE, so there is no same-cycle accept.
- Sign of the result is always 0.
- Specials:
  - Zero or denormal input → +0, no flags.
  - ±Inf → 32'h7F800000, no overflow flag.
  - NaN → canonical 32'h7FC00000.
- Latency:
  - Normal operand: accept edge to out_valid = 26 cycles (1 + 24 + 1).
  - Special operand: 1 cycle.
- Throughput: one result per 27 cycles minimum, with out_ready held high.
- in_valid while busy is ignored; the source must hold it until in_ready.
- out_ready low stalls indefinitely without corrupting the result.

Optional Feature:
- FP_SQUARE_ROUND_NEAREST_EN defined: NORM applies round-to-nearest-even.
  - Guard bit = bit just below the kept LSB; sticky = OR of all lower acc bits.
  - Increment when guard & (sticky | lsb).
  - A mantissa carry-out sets frac=0 and e+=1, before the overflow check.
- Undefined: truncation, with no rounding logic generated.

Decomposition:
- Shared package fp_pkg:
  - Constants FP_BIAS=127, FP_QNAN=32'h7FC00000, FP_PINF=32'h7F800000, FP_ZERO.
  - State typedef for fp_square_seq (IDLE/MUL/NORM/DONE).
  - Classification helper constants for exp==0 and exp==255.
- One sub-module: mant_mul_seq, a 24x24 shift-add iterative multiplier with start/done, owning acc and cnt.
- fp_square_seq owns the handshake FSM, exponent arithmetic, normalisation, rounding and special cases.

Test Plan:
- 32'h40400000 (3.0) → solution 32'h41100000 (9.0), out_valid exactly 26 cycles after accept, flags 0.
- 32'hC0000000 (-2.0) → 32'h40800000 (4.0); 32'h3FC00000 (1.5) → 32'h40100000 (2.25).
- Specials:
  - 32'h7FC00001 → 32'h7FC00000.
  - 32'hFF800000 → 32'h7F800000.
  - 32'h80000000 → 32'h00000000.
  - Each with out_valid 1 cycle after accept.
- Range limits:
  - 32'h7149F2CA (~1e30) → 32'h7F800000 with overflow=1.
  - 32'h0DA24260 (~1e-30) → 32'h00000000 with underflow=1.
- 32'h3FC00001 → 32'h40100001 by default; 32'h40100002 with FP_SQUARE_ROUND_NEAREST_EN.
- Control behaviour:
  - out_ready held 0 for 10 cycles: solution stable, in_ready=0.
  - reset asserted at MUL cycle 12: next cycle IDLE, out_valid=0, and no result is ever emitted for that operand.
